// File: rtl/pn2112_seq_ctl.sv
// PN2112 training-burst sequencer: streams 33-word generator frames downstream,
// restarting a frame on a ready break and stopping on count, retry limit or abort.
module pn2112_seq_ctl #(
  parameter int unsigned GAP_LEN   = 2,
  parameter int unsigned MAX_RETRY = 15,
  localparam int unsigned DW       = 64,
  localparam int unsigned CW       = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [CW-1:0] frame_cnt,
  input  logic          tx_rdy,
  input  logic [DW-1:0] pn_cw,
  output logic          pn_ena,
  output logic [DW-1:0] tx_data,
  output logic          tx_vld,
  output logic          tx_sof,
  output logic          tx_eof,
  output logic          tx_abt,
  output logic          busy,
  output logic          done,
  output logic          fail,
  output logic          aborted,
  output logic [CW-1:0] frames_sent,
  output logic [CW-1:0] retries
);

  localparam int unsigned IW = 6;
  localparam int unsigned GW = 4;
  localparam logic [IW-1:0] LAST_IDX = IW'(32);

  typedef enum logic [2:0] {
    IDLE, WAIT_RDY, PRIME, SEND, GAP, FIN
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [CW-1:0] retry_q, retry_d;
  logic [CW-1:0] target_q, target_d;
  logic [CW-1:0] sent_q, sent_d;
  logic [CW-1:0] retries_q, retries_d;
  logic          fail_q, fail_d;
  logic          abt_q, abt_d;
  logic          aborted_q, aborted_d;

  // Next-state and datapath update; abort outranks every other event.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    gap_d     = gap_q;
    retry_d   = retry_q;
    target_d  = target_q;
    sent_d    = sent_q;
    retries_d = retries_q;
    fail_d    = fail_q;
    abt_d     = 1'b0;
    aborted_d = 1'b0;

    if (abort && state_q != IDLE) begin
      state_d   = IDLE;
      idx_d     = '0;
      gap_d     = '0;
      aborted_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            fail_d = 1'b0;
            if (frame_cnt != '0) begin
              target_d  = frame_cnt;
              sent_d    = '0;
              retries_d = '0;
              retry_d   = '0;
              idx_d     = '0;
              state_d   = WAIT_RDY;
            end else begin
              state_d = FIN;
            end
          end
        end
        WAIT_RDY: begin
          if (tx_rdy) state_d = PRIME;
        end
        PRIME: begin
          idx_d   = '0;
          state_d = SEND;
        end
        SEND: begin
          if (!tx_rdy) begin
            // Frame break: restart from word 0, flag a restart only if words went out.
            idx_d   = '0;
            retry_d = retry_q + CW'(1);
            abt_d   = (idx_q != '0);
            if (retries_q != '1) retries_d = retries_q + CW'(1);
            if (32'(retry_q) + 32'd1 > MAX_RETRY) begin
              fail_d  = 1'b1;
              state_d = FIN;
            end else begin
              state_d = WAIT_RDY;
            end
          end else if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            gap_d   = '0;
            retry_d = '0;
            sent_d  = sent_q + CW'(1);
            state_d = ((sent_q + CW'(1)) == target_q) ? FIN : GAP;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
        GAP: begin
          if (32'(gap_q) + 32'd1 >= GAP_LEN) begin
            gap_d   = '0;
            state_d = WAIT_RDY;
          end else begin
            gap_d = gap_q + GW'(1);
          end
        end
        FIN:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      gap_q     <= '0;
      retry_q   <= '0;
      target_q  <= '0;
      sent_q    <= '0;
      retries_q <= '0;
      fail_q    <= 1'b0;
      abt_q     <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      gap_q     <= gap_d;
      retry_q   <= retry_d;
      target_q  <= target_d;
      sent_q    <= sent_d;
      retries_q <= retries_d;
      fail_q    <= fail_d;
      abt_q     <= abt_d;
      aborted_q <= aborted_d;
    end
  end

  // Stream controls decode from registered state/index only.
  assign pn_ena      = (state_q == PRIME) || (state_q == SEND);
  assign tx_vld      = (state_q == SEND);
  assign tx_sof      = (state_q == SEND) && (idx_q == '0);
  assign tx_eof      = (state_q == SEND) && (idx_q == LAST_IDX);
  assign tx_data     = pn_cw;
  assign tx_abt      = abt_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == FIN);
  assign fail        = (state_q == FIN) && fail_q;
  assign aborted     = aborted_q;
  assign frames_sent = sent_q;
  assign retries     = retries_q;

endmodule

// File: tb/tb_pn2112_seq_ctl.sv
// Directed bench for pn2112_seq_ctl with a behavioural PN2112 word generator.
module tb_pn2112_seq_ctl;

  localparam int unsigned GAP_LEN   = 2;
  localparam int unsigned MAX_RETRY = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  frame_cnt = '0;
  logic        tx_rdy = 1'b1;
  logic [63:0] pn_cw = '0;
  logic        pn_ena;
  logic [63:0] tx_data;
  logic        tx_vld, tx_sof, tx_eof, tx_abt;
  logic        busy, done, fail, aborted;
  logic [7:0]  frames_sent, retries;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pn2112_seq_ctl #(.GAP_LEN(GAP_LEN), .MAX_RETRY(MAX_RETRY)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .frame_cnt(frame_cnt),
    .tx_rdy(tx_rdy), .pn_cw(pn_cw), .pn_ena(pn_ena), .tx_data(tx_data),
    .tx_vld(tx_vld), .tx_sof(tx_sof), .tx_eof(tx_eof), .tx_abt(tx_abt),
    .busy(busy), .done(done), .fail(fail), .aborted(aborted),
    .frames_sent(frames_sent), .retries(retries)
  );

  function automatic logic [63:0] gen_word(input int i);
    return {32'hC0DE_0000 + 32'(i), 32'h5A5A_5A5A ^ 32'(i * 3)};
  endfunction

  // Generator model: word index restarts whenever the enable is low.
  int gidx = 0;
  always @(posedge clk) begin
    if (pn_ena) begin
      pn_cw <= gen_word(gidx);
      gidx  <= gidx + 1;
    end else begin
      gidx <= 0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [7:0] n);
    frame_cnt = n;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  int         r_words, r_abt, r_brk;
  logic       r_done, r_fail;
  logic [7:0] r_sent, r_retries;

  // mode 0: always ready; mode 1: one-cycle break at (bf, bi); mode 2: never ready in SEND
  task automatic run_burst(input int mode, input int bf, input int bi, input int max_cyc);
    int exp_idx = 0;
    int frames  = 0;
    int gap     = 0;
    bit gap_trk = 0;
    bit broke   = 0;
    bit abt_exp = 0;
    bit fin     = 0;
    r_words = 0; r_abt = 0; r_brk = 0;
    r_done = 1'b0; r_fail = 1'b0; r_sent = '0; r_retries = '0;
    for (int c = 0; c < max_cyc && !fin; c++) begin
      chk("tx_abt", 64'(tx_abt), 64'(abt_exp));
      r_abt += int'(tx_abt);
      abt_exp = 0;
      if (done) begin
        r_done = 1'b1; r_fail = fail; r_sent = frames_sent; r_retries = retries;
        chk("vld_at_done", 64'(tx_vld), 64'd0);
        tick();
        chk("busy_after_done", 64'(busy), 64'd0);
        fin = 1;
      end else if (tx_vld) begin
        if (gap_trk) begin
          chk("gap_len", 64'(gap), 64'(GAP_LEN + 2));
          gap_trk = 0;
        end
        chk("tx_sof", 64'(tx_sof), 64'(exp_idx == 0));
        chk("tx_eof", 64'(tx_eof), 64'(exp_idx == 32));
        chk("tx_data", tx_data, gen_word(exp_idx));
        if (mode == 2) tx_rdy = 1'b0;
        else if (mode == 1 && !broke && frames == bf && exp_idx == bi) begin
          tx_rdy = 1'b0;
          broke  = 1;
        end else tx_rdy = 1'b1;
        if (tx_rdy) begin
          r_words++;
          if (exp_idx == 32) begin
            exp_idx = 0; frames++; gap_trk = 1; gap = 0;
          end else exp_idx++;
        end else begin
          r_brk++;
          abt_exp = (exp_idx != 0);
          exp_idx = 0;
        end
        tick();
      end else begin
        tx_rdy = 1'b1;
        if (gap_trk) gap++;
        tick();
      end
    end
    tx_rdy = 1'b1;
    if (!fin) chk("done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int  xfers;
    bit  hit;

    // reset state
    tick(); tick();
    chk("rst_flags", 64'({pn_ena, tx_vld, tx_sof, tx_eof, tx_abt, busy, done, fail, aborted}), 64'd0);
    chk("rst_counts", 64'({frames_sent, retries}), 64'd0);
    rst = 1'b0;
    tick();

    // abort while idle does nothing
    abort = 1'b1; tick(); abort = 1'b0;
    chk("idle_abort_busy", 64'(busy), 64'd0);
    chk("idle_abort_pulse", 64'(aborted), 64'd0);

    // two clean frames
    go(8'd2);
    run_burst(0, 0, 0, 400);
    chk("a_done", 64'(r_done), 64'd1);
    chk("a_fail", 64'(r_fail), 64'd0);
    chk("a_sent", 64'(r_sent), 64'd2);
    chk("a_retries", 64'(r_retries), 64'd0);
    chk("a_words", 64'(r_words), 64'd66);
    chk("a_abt", 64'(r_abt), 64'd0);
    tick();

    // one-cycle break at word 10 of the first frame
    go(8'd2);
    run_burst(1, 0, 10, 400);
    chk("b_done", 64'(r_done), 64'd1);
    chk("b_fail", 64'(r_fail), 64'd0);
    chk("b_sent", 64'(r_sent), 64'd2);
    chk("b_retries", 64'(r_retries), 64'd1);
    chk("b_words", 64'(r_words), 64'd76);
    chk("b_abt", 64'(r_abt), 64'd1);
    tick();

    // ready never high in SEND: retry limit
    go(8'd1);
    run_burst(2, 0, 0, 300);
    chk("c_done", 64'(r_done), 64'd1);
    chk("c_fail", 64'(r_fail), 64'd1);
    chk("c_retries", 64'(r_retries), 64'(MAX_RETRY + 1));
    chk("c_breaks", 64'(r_brk), 64'(MAX_RETRY + 1));
    chk("c_sent", 64'(r_sent), 64'd0);
    chk("c_abt", 64'(r_abt), 64'd0);
    tick();

    // zero-frame burst
    go(8'd0);
    chk("d_done", 64'(done), 64'd1);
    chk("d_fail", 64'(fail), 64'd0);
    chk("d_vld", 64'(tx_vld), 64'd0);
    tick();
    chk("d_done_clr", 64'(done), 64'd0);
    chk("d_busy_clr", 64'(busy), 64'd0);

    // abort coinciding with the last EOF
    go(8'd1);
    xfers = 0; hit = 0;
    for (int c = 0; c < 100 && !hit; c++) begin
      if (tx_vld && xfers == 32) begin
        abort = 1'b1; tick(); abort = 1'b0; hit = 1;
      end else begin
        if (tx_vld) xfers++;
        tick();
      end
    end
    chk("e_reached_eof", 64'(hit), 64'd1);
    chk("e_aborted", 64'(aborted), 64'd1);
    chk("e_idle", 64'({busy, done, tx_vld, pn_ena}), 64'd0);
    chk("e_sent", 64'(frames_sent), 64'd0);
    tick();
    chk("e_pulse_end", 64'({aborted, done}), 64'd0);

    // asynchronous reset mid-SEND
    go(8'd1);
    hit = 0;
    for (int c = 0; c < 10 && !hit; c++) begin
      if (tx_vld) hit = 1; else tick();
    end
    chk("f_in_send", 64'(hit), 64'd1);
    tick(); tick(); tick();
    #1 rst = 1'b1;
    #1;
    chk("f_rst_flags", 64'({pn_ena, tx_vld, tx_sof, tx_eof, tx_abt, busy, done, fail, aborted}), 64'd0);
    chk("f_rst_counts", 64'({frames_sent, retries}), 64'd0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("f_silent", 64'({done, fail, aborted, busy}), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
